// File: rtl/minigpu_pkg.sv
// Shared definitions for the triangle batch fetcher: FSM encoding,
// edge-record field layout and vertex-index width.
package minigpu_pkg;

    localparam int IDX_W     = 16;
    localparam int EDGE_OFF0 = 0;
    localparam int EDGE_OFF1 = 16;
    localparam int EDGE_OFF2 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        E_REQ  = 3'd1,
        E_WAIT = 3'd2,
        V_REQ  = 3'd3,
        V_WAIT = 3'd4,
        OUT    = 3'd5,
        DONE   = 3'd6
    } draw_state_e;

    function automatic logic [IDX_W-1:0] edge_field(input logic [3*IDX_W-1:0] rec,
                                                    input logic [1:0]         k);
        case (k)
            2'd1:    return rec[EDGE_OFF1 +: IDX_W];
            2'd2:    return rec[EDGE_OFF2 +: IDX_W];
            default: return rec[EDGE_OFF0 +: IDX_W];
        endcase
    endfunction

    function automatic logic is_degenerate(input logic [3*IDX_W-1:0] rec);
        logic [IDX_W-1:0] a, b, c;
        a = rec[EDGE_OFF0 +: IDX_W];
        b = rec[EDGE_OFF1 +: IDX_W];
        c = rec[EDGE_OFF2 +: IDX_W];
        return (a == b) || (b == c) || (a == c);
    endfunction

endpackage

// File: rtl/cmd_draw_tri_batch_if.sv
// Command, RAM-port and triangle-output signals of the batch fetcher.
// master = the fetcher itself, slave = command source / RAMs / consumer.
interface cmd_draw_tri_batch_if #(
    parameter int DEPTH     = 1024,
    parameter int DW_VERTEX = 64,
    parameter int DW_EDGE   = 48,
    parameter int CW        = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                 draw_req_pulse;
    logic [15:0]          edge_addr;
    logic [CW-1:0]        tri_count;
    logic [DW_EDGE-1:0]   edge_data;
    logic [DW_VERTEX-1:0] vertex_data;
    logic [AW-1:0]        ADDR_EDGE;
    logic                 RE_EDGE;
    logic [AW-1:0]        ADDR_VERTEX;
    logic                 RE_VERTEX;
    logic                 tri_valid;
    logic                 tri_ready;
    logic [DW_VERTEX-1:0] tri_v0;
    logic [DW_VERTEX-1:0] tri_v1;
    logic [DW_VERTEX-1:0] tri_v2;
    logic [CW-1:0]        tri_idx;
    logic                 BUSY;
    logic                 done_pulse;
    logic                 err_range;

    modport master (
        input  draw_req_pulse, edge_addr, tri_count, edge_data, vertex_data, tri_ready,
        output ADDR_EDGE, RE_EDGE, ADDR_VERTEX, RE_VERTEX, tri_valid,
               tri_v0, tri_v1, tri_v2, tri_idx, BUSY, done_pulse, err_range
    );

    modport slave (
        output draw_req_pulse, edge_addr, tri_count, edge_data, vertex_data, tri_ready,
        input  ADDR_EDGE, RE_EDGE, ADDR_VERTEX, RE_VERTEX, tri_valid,
               tri_v0, tri_v1, tri_v2, tri_idx, BUSY, done_pulse, err_range
    );

endinterface

// File: rtl/draw_rd_timer.sv
// Loadable down-counter timing a RAM read; done_o is high in the cycle the
// read data is due (RD_LAT-th cycle after the load).
module draw_rd_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/cmd_draw_tri_batch.sv
// Triangle batch fetcher: per triangle one edge read then three vertex reads,
// presented on a valid/ready output. Define DRAW_TRI_CULL_EN to skip degenerate records.
module cmd_draw_tri_batch
    import minigpu_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int DW_VERTEX = 64,
    parameter int DW_EDGE   = 48,
    parameter int RD_LAT    = 1,
    parameter int CW        = 8
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    cmd_draw_tri_batch_if.master  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = 4;

    draw_state_e          state_q, state_d, adv_state;
    logic [IDX_W-1:0]     base_q, base_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW:0]          i_q, i_d, i_inc;
    logic [1:0]           k_q, k_d;
    logic [DW_EDGE-1:0]   edge_q, edge_d;
    logic [DW_VERTEX-1:0] vtx_q [3];
    logic                 err_q, err_d;

    logic                 vtx_ld, clr, t_done, re_edge, re_vertex, cull;
    logic                 e_in_range, v_in_range;
    logic [IDX_W:0]       e_addr_full;
    logic [IDX_W-1:0]     fld;
    logic [AW-1:0]        addr_edge, addr_vertex;

    // Range checks are done at 17 bits so base+i can never alias into the RAM.
    assign e_addr_full = {1'b0, base_q} + (IDX_W+1)'(i_q);
    assign e_in_range  = e_addr_full < (IDX_W+1)'(DEPTH);
    assign fld         = edge_field(edge_q[3*IDX_W-1:0], k_q);
    assign v_in_range  = {1'b0, fld} < (IDX_W+1)'(DEPTH);
    assign i_inc       = i_q + 1'b1;
    assign adv_state   = (i_inc < {1'b0, count_q}) ? E_REQ : DONE;

`ifdef DRAW_TRI_CULL_EN
    assign cull = is_degenerate(edge_q[3*IDX_W-1:0]);
`else
    assign cull = 1'b0;
`endif

    draw_rd_timer #(.W(TW)) u_timer (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .load_i     (re_edge | re_vertex),
        .load_val_i (TW'(RD_LAT)),
        .done_o     (t_done)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        i_d         = i_q;
        k_d         = k_q;
        edge_d      = edge_q;
        err_d       = err_q;
        re_edge     = 1'b0;
        re_vertex   = 1'b0;
        addr_edge   = '0;
        addr_vertex = '0;
        vtx_ld      = 1'b0;
        clr         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.draw_req_pulse) begin
                    err_d = 1'b0;
                    if (bus.tri_count == '0) begin
                        state_d = DONE;
                    end else begin
                        base_d  = bus.edge_addr;
                        count_d = bus.tri_count;
                        i_d     = '0;
                        state_d = E_REQ;
                    end
                end
            end
            E_REQ: begin
                if (!e_in_range) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    re_edge   = 1'b1;
                    addr_edge = e_addr_full[AW-1:0];
                    state_d   = E_WAIT;
                end
            end
            E_WAIT: begin
                if (t_done) begin
                    edge_d  = bus.edge_data;
                    k_d     = 2'd0;
                    state_d = V_REQ;
                end
            end
            V_REQ: begin
                // Culled or out-of-range triangles are dropped without output.
                if (k_q == 2'd0 && cull) begin
                    i_d     = i_inc;
                    state_d = adv_state;
                end else if (!v_in_range) begin
                    err_d   = 1'b1;
                    i_d     = i_inc;
                    state_d = adv_state;
                end else begin
                    re_vertex   = 1'b1;
                    addr_vertex = fld[AW-1:0];
                    state_d     = V_WAIT;
                end
            end
            V_WAIT: begin
                if (t_done) begin
                    vtx_ld = 1'b1;
                    if (k_q == 2'd2) begin
                        state_d = OUT;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = V_REQ;
                    end
                end
            end
            OUT: begin
                if (bus.tri_ready) begin
                    i_d     = i_inc;
                    state_d = adv_state;
                end
            end
            DONE: begin
                clr     = 1'b1;
                base_d  = '0;
                count_d = '0;
                i_d     = '0;
                k_d     = '0;
                edge_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            i_q     <= '0;
            k_q     <= '0;
            edge_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            i_q     <= i_d;
            k_q     <= k_d;
            edge_q  <= edge_d;
            err_q   <= err_d;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_vtx
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                vtx_q[gi] <= '0;
            end else if (clr) begin
                vtx_q[gi] <= '0;
            end else if (vtx_ld && k_q == 2'(gi)) begin
                vtx_q[gi] <= bus.vertex_data;
            end
        end
    end

    assign bus.ADDR_EDGE   = addr_edge;
    assign bus.RE_EDGE     = re_edge;
    assign bus.ADDR_VERTEX = addr_vertex;
    assign bus.RE_VERTEX   = re_vertex;
    assign bus.tri_valid   = (state_q == OUT);
    assign bus.tri_v0      = vtx_q[0];
    assign bus.tri_v1      = vtx_q[1];
    assign bus.tri_v2      = vtx_q[2];
    assign bus.tri_idx     = i_q[CW-1:0];
    assign bus.BUSY        = (state_q != IDLE) && (state_q != DONE);
    assign bus.done_pulse  = (state_q == DONE);
    assign bus.err_range   = err_q;

endmodule

// File: tb/tb_cmd_draw_tri_batch.sv
// Scoreboard bench: two fetchers (RD_LAT 1 and 3) run the same directed batches
// against shared RAM models; a negedge monitor pops expected triangles/done events.
module tb_cmd_draw_tri_batch;

    localparam int DEPTH = 1024;
    localparam int DWV   = 64;
    localparam int DWE   = 48;
    localparam int CW    = 8;

    typedef struct packed {
        logic [63:0] v0;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [7:0]  idx;
    } tri_t;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic          req = 1'b0;
    logic [15:0]   addr = '0;
    logic [CW-1:0] cnt = '0;
    bit            stall_mode = 1'b0;
    logic [1:0]    rdy_v = 2'b11;

    logic [47:0] emem [DEPTH];
    tri_t        exp_tri [2][$];
    bit          exp_err [2][$];
    int          done_cnt [2];

    logic [1:0]  valid_v, busy_v, done_v, err_v, ree_v, rev_v;
    logic [63:0] v0_s [2];
    logic [63:0] v1_s [2];
    logic [63:0] v2_s [2];
    logic [7:0]  idx_s [2];

    function automatic logic [63:0] vword(input int a);
        logic [15:0] s;
        s = a[15:0];
        return {16'hBEEF ^ s, s, 16'h5A5A, s + 16'd100};
    endfunction

    function automatic logic [47:0] rec(input int a, input int b, input int c);
        return {c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic tri_t mk_tri(input int a, input int b, input int c, input int idx);
        tri_t t;
        t.v0 = vword(a);
        t.v1 = vword(b);
        t.v2 = vword(c);
        t.idx = idx[7:0];
        return t;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;

        cmd_draw_tri_batch_if #(.DEPTH(DEPTH), .DW_VERTEX(DWV), .DW_EDGE(DWE), .CW(CW)) bus ();

        cmd_draw_tri_batch #(
            .DEPTH(DEPTH), .DW_VERTEX(DWV), .DW_EDGE(DWE), .RD_LAT(LAT), .CW(CW)
        ) dut (
            .CLK   (CLK),
            .rst_n (rst_n),
            .bus   (bus)
        );

        logic [47:0] epipe [LAT];
        logic [63:0] vpipe [LAT];

        always @(posedge CLK) begin
            for (int j = LAT - 1; j > 0; j--) begin
                epipe[j] <= epipe[j-1];
                vpipe[j] <= vpipe[j-1];
            end
            if (bus.RE_EDGE)   epipe[0] <= emem[bus.ADDR_EDGE];
            if (bus.RE_VERTEX) vpipe[0] <= vword(int'(bus.ADDR_VERTEX));
        end

        assign bus.draw_req_pulse = req;
        assign bus.edge_addr      = addr;
        assign bus.tri_count      = cnt;
        assign bus.edge_data      = epipe[LAT-1];
        assign bus.vertex_data    = vpipe[LAT-1];
        assign bus.tri_ready      = rdy_v[gi];

        assign valid_v[gi] = bus.tri_valid;
        assign busy_v[gi]  = bus.BUSY;
        assign done_v[gi]  = bus.done_pulse;
        assign err_v[gi]   = bus.err_range;
        assign ree_v[gi]   = bus.RE_EDGE;
        assign rev_v[gi]   = bus.RE_VERTEX;
        assign v0_s[gi]    = bus.tri_v0;
        assign v1_s[gi]    = bus.tri_v1;
        assign v2_s[gi]    = bus.tri_v2;
        assign idx_s[gi]   = bus.tri_idx;
    end

    // Ready generator: in stall mode each triangle is held off for 5 cycles.
    initial begin
        int wcnt [2];
        wcnt[0] = 0;
        wcnt[1] = 0;
        forever begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (valid_v[i]) begin
                    if (!stall_mode || wcnt[i] >= 5) begin
                        rdy_v[i] = 1'b1;
                    end else begin
                        rdy_v[i] = 1'b0;
                        wcnt[i]++;
                    end
                end else begin
                    rdy_v[i] = !stall_mode;
                    wcnt[i] = 0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        tri_t cur, e, prev_tri [2];
        bit   prev_stall [2];
        bit   eerr;
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                cur.v0 = v0_s[i];
                cur.v1 = v1_s[i];
                cur.v2 = v2_s[i];
                cur.idx = idx_s[i];
                if (!rst_n) begin
                    prev_stall[i] = 1'b0;
                end else begin
                    if (valid_v[i] && prev_stall[i]) begin
                        checks++;
                        if (cur != prev_tri[i]) begin
                            failures++;
                            $display("FAIL stable inst=%0d got idx=%0d v0=%h required idx=%0d v0=%h",
                                     i, cur.idx, cur.v0, prev_tri[i].idx, prev_tri[i].v0);
                        end
                    end
                    if (valid_v[i] && rdy_v[i]) begin
                        checks++;
                        if (exp_tri[i].size() == 0) begin
                            failures++;
                            $display("FAIL tri_unexpected inst=%0d got idx=%0d v0=%h required no triangle",
                                     i, cur.idx, cur.v0);
                        end else begin
                            e = exp_tri[i].pop_front();
                            if (cur != e) begin
                                failures++;
                                $display("FAIL tri inst=%0d got idx=%0d v0=%h v1=%h v2=%h required idx=%0d v0=%h v1=%h v2=%h",
                                         i, cur.idx, cur.v0, cur.v1, cur.v2, e.idx, e.v0, e.v1, e.v2);
                            end
                        end
                    end
                    if (done_v[i]) begin
                        checks++;
                        done_cnt[i]++;
                        if (exp_err[i].size() == 0) begin
                            failures++;
                            $display("FAIL done_unexpected inst=%0d got done_pulse=1 required 0", i);
                        end else begin
                            eerr = exp_err[i].pop_front();
                            if (err_v[i] !== eerr || busy_v[i] !== 1'b0) begin
                                failures++;
                                $display("FAIL done inst=%0d got err_range=%0b BUSY=%0b required err_range=%0b BUSY=0",
                                         i, err_v[i], busy_v[i], eerr);
                            end
                        end
                    end
                    if (ree_v[i] && rev_v[i]) begin
                        failures++;
                        $display("FAIL strobe_overlap inst=%0d got RE_EDGE=1 RE_VERTEX=1 required at most one", i);
                    end
                    prev_stall[i] = valid_v[i] && !rdy_v[i];
                end
                prev_tri[i] = cur;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, expv);
        end
    endtask

    task automatic push_tri(input tri_t t);
        exp_tri[0].push_back(t);
        exp_tri[1].push_back(t);
    endtask

    task automatic push_done(input bit err);
        exp_err[0].push_back(err);
        exp_err[1].push_back(err);
    endtask

    task automatic issue(input int a, input int c);
        @(negedge CLK);
        addr = a[15:0];
        cnt  = c[CW-1:0];
        req  = 1'b1;
        @(negedge CLK);
        req  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 3000; k++) begin
            @(posedge CLK);
            if (done_cnt[0] >= target && done_cnt[1] >= target) return;
        end
        failures++;
        $display("FAIL wait_done got done_cnt=%0d/%0d required %0d", done_cnt[0], done_cnt[1], target);
    endtask

    initial begin
        int ndone;
        int lat [2];
        ndone = 0;
        for (int a = 0; a < DEPTH; a++) emem[a] = '0;
        emem[5]    = rec(2, 3, 4);
        emem[10]   = rec(10, 11, 12);
        emem[11]   = rec(20, 21, 22);
        emem[12]   = rec(30, 31, 32);
        emem[13]   = rec(40, 41, 42);
        emem[1022] = rec(50, 51, 52);
        emem[1023] = rec(60, 61, 62);
        emem[19]   = rec(1, 2, 3);
        emem[20]   = rec(5, 16'h0500, 6);
        emem[21]   = rec(8, 9, 10);
        emem[30]   = rec(100, 101, 102);
        emem[31]   = rec(103, 104, 105);
        emem[40]   = rec(7, 7, 9);
        emem[41]   = rec(11, 12, 13);

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_valid", 64'(valid_v), 64'd0);
        chk("rst_busy",  64'(busy_v),  64'd0);
        chk("rst_done",  64'(done_v),  64'd0);
        chk("rst_err",   64'(err_v),   64'd0);
        chk("rst_strobe", 64'({ree_v, rev_v}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Single triangle, latency, request while busy ignored
        push_tri(mk_tri(2, 3, 4, 0));
        push_done(1'b0);
        lat[0] = 0;
        lat[1] = 0;
        @(negedge CLK);
        addr = 16'd5; cnt = 8'd1; req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) req = 1'b0;
            if (k == 2) begin addr = 16'd10; cnt = 8'd4; req = 1'b1; end
            if (k == 3) req = 1'b0;
            for (int i = 0; i < 2; i++) if (valid_v[i] && lat[i] == 0) lat[i] = k;
        end
        chk("latency_rdlat1", 64'(lat[0]), 64'd9);
        chk("latency_rdlat3", 64'(lat[1]), 64'd17);
        ndone++;
        wait_done(ndone);

        // Four triangles with 5-cycle stalls
        stall_mode = 1'b1;
        push_tri(mk_tri(10, 11, 12, 0));
        push_tri(mk_tri(20, 21, 22, 1));
        push_tri(mk_tri(30, 31, 32, 2));
        push_tri(mk_tri(40, 41, 42, 3));
        push_done(1'b0);
        issue(10, 4);
        ndone++;
        wait_done(ndone);
        stall_mode = 1'b0;

        // Edge address runs past the end of the RAM
        push_tri(mk_tri(50, 51, 52, 0));
        push_tri(mk_tri(60, 61, 62, 1));
        push_done(1'b1);
        issue(1022, 4);
        ndone++;
        wait_done(ndone);
        chk("range_err_sticky", 64'(err_v), 64'h3);

        // Out-of-range vertex index skips one triangle only
        push_tri(mk_tri(1, 2, 3, 0));
        push_tri(mk_tri(8, 9, 10, 2));
        push_done(1'b1);
        issue(19, 3);
        chk("new_req_clears_err", 64'(err_v), 64'd0);
        chk("new_req_busy", 64'(busy_v), 64'h3);
        ndone++;
        wait_done(ndone);

        // Reset while both fetchers wait on a vertex read
        issue(30, 2);
        repeat (5) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_v), 64'd0);
        chk("midrst_busy",  64'(busy_v),  64'd0);
        chk("midrst_strobe", 64'({ree_v, rev_v}), 64'd0);
        chk("midrst_v0", v0_s[0], 64'd0);
        chk("midrst_err", 64'(err_v), 64'd0);
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
`ifndef DRAW_TRI_CULL_EN
        push_tri(mk_tri(7, 7, 9, 0));
`endif
        push_tri(mk_tri(11, 12, 13, 1));
        push_done(1'b0);
        issue(40, 2);
        ndone++;
        wait_done(ndone);

        // Zero-count request
        push_done(1'b0);
        @(negedge CLK);
        addr = 16'd5; cnt = 8'd0; req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        chk("cnt0_done", 64'(done_v), 64'h3);
        chk("cnt0_busy", 64'(busy_v), 64'd0);
        chk("cnt0_strobe", 64'({ree_v, rev_v}), 64'd0);
        @(negedge CLK);
        chk("cnt0_done_one_cycle", 64'(done_v), 64'd0);
        ndone++;
        wait_done(ndone);

        repeat (5) @(negedge CLK);
        chk("tri_queue_empty0", 64'(exp_tri[0].size()), 64'd0);
        chk("tri_queue_empty1", 64'(exp_tri[1].size()), 64'd0);
        chk("done_queue_empty", 64'(exp_err[0].size() + exp_err[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_draw_tri_batch.md
CMD_DRAW_TRI_BATCH -- requirements
Module: cmd_draw_tri_batch

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of entries in the edge RAM and in the vertex RAM.
REQ-002 SHALL have parameter DW_VERTEX, default 64: width of one vertex word.
REQ-003 SHALL have parameter DW_EDGE, default 48: width of one edge record, holding three 16-bit vertex indices at bits [15:0], [31:16] and [47:32].
REQ-004 SHALL have parameter RD_LAT, default 1, legal range 1..8: RAM read latency in cycles.
REQ-005 SHALL have parameter CW, default 8: width of the triangle-count field.
REQ-006 CLK  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 draw_req_pulse  in  1  one-cycle start request.
REQ-009 edge_addr  in  16  index of the first edge record.
REQ-010 tri_count  in  CW  number of consecutive edge records to draw.
REQ-011 edge_data  in  DW_EDGE  edge RAM read data.
REQ-012 vertex_data  in  DW_VERTEX  vertex RAM read data.
REQ-013 ADDR_EDGE  out  clog2(DEPTH)  edge RAM address.
REQ-014 RE_EDGE  out  1  edge RAM read strobe.
REQ-015 ADDR_VERTEX  out  clog2(DEPTH)  vertex RAM address.
REQ-016 RE_VERTEX  out  1  vertex RAM read strobe.
REQ-017 tri_valid  out  1  a triangle is presented on the output.
REQ-018 tri_ready  in  1  the downstream stage accepts the triangle.
REQ-019 tri_v0, tri_v1, tri_v2  out  DW_VERTEX each  the three vertex words of the triangle.
REQ-020 tri_idx  out  CW  ordinal of the triangle within the batch.
REQ-021 BUSY  out  1  the batch is in progress.
REQ-022 done_pulse  out  1  one-cycle end-of-batch indication.
REQ-023 err_range  out  1  sticky address-range error.

Function
REQ-024 SHALL use the FSM states IDLE, E_REQ, E_WAIT, V_REQ, V_WAIT, OUT and DONE.
REQ-025 IDLE: draw_req_pulse with tri_count=0 SHALL produce done_pulse in the next cycle, leave BUSY at 0 and clear err_range.
REQ-026 IDLE: draw_req_pulse with tri_count≠0 SHALL latch edge_addr and tri_count, clear err_range, set BUSY=1 and go to E_REQ.
REQ-027 draw_req_pulse while BUSY=1 SHALL be ignored.
REQ-028 E_REQ: if base+i ≥ DEPTH (17-bit compare), SHALL set err_range and go to DONE, aborting the remainder of the batch; otherwise SHALL drive ADDR_EDGE=base+i with RE_EDGE=1 for exactly one cycle and go to E_WAIT.
REQ-029 E_WAIT: SHALL count RD_LAT cycles, sample edge_data in the RD_LAT-th cycle after the strobe, set vertex select k=0 and go to V_REQ.
REQ-030 V_REQ: if index field k ≥ DEPTH, SHALL set err_range and skip the triangle (no output) by advancing i; otherwise SHALL drive ADDR_VERTEX=field k with RE_VERTEX=1 for one cycle and go to V_WAIT.
REQ-031 V_WAIT: after RD_LAT cycles SHALL latch vertex_data into vertex slot k; if k<2, SHALL increment k and return to V_REQ; if k=2, SHALL go to OUT.
REQ-032 OUT: tri_valid=1, with tri_v0/v1/v2 and tri_idx held stable until the cycle in which tri_ready=1.
REQ-033 In the OUT handshake cycle, SHALL increment i and go to E_REQ if i+1<count, else go to DONE.
REQ-034 An unskipped triangle SHALL take 4×(1+RD_LAT)+1 cycles when tri_ready is held high.
REQ-035 DONE: SHALL assert done_pulse for one cycle, clear BUSY and the latched data, and return to IDLE.
REQ-036 At most one RAM strobe SHALL be active in any cycle.
REQ-037 The internal counter i SHALL be CW+1 bits wide so that a count of 2^CW-1 cannot wrap.

Reset
REQ-038 On rst_n=0, at any time including mid-batch, all outputs, the FSM, the counters and the latched data SHALL go to 0 / IDLE immediately.
REQ-039 A pending tri_valid SHALL be dropped by reset.

Configuration
REQ-040 With DRAW_TRI_CULL_EN defined, after the edge fetch any record with two equal indices SHALL be skipped as degenerate: no vertex reads and no output for it.
REQ-041 With DRAW_TRI_CULL_EN undefined, degenerate records SHALL be drawn normally.

Structure
REQ-042 minigpu_pkg SHALL hold the state encoding, the edge field offsets (0, 16, 32) and the 16-bit index width.
REQ-043 SHALL contain one sub-module, draw_rd_timer: loadable down-counter with a done flag, reused for both the edge and the vertex waits.

Verification
REQ-044 RD_LAT=1, edge[5]={2,3,4}, distinct vertices, tri_ready=1, req addr=5 cnt=1 -> one tri_valid cycle with the three vertices in order, then done_pulse, 9 cycles strobe-to-valid.
REQ-045 RD_LAT=3, cnt=4 from addr 10, tri_ready low for 5 cycles on each triangle -> tri_idx 0..3 in order, output data stable while stalled, 4 handshakes.
REQ-046 addr=1022, cnt=4, DEPTH=1024 -> 2 triangles, then err_range=1, done_pulse, BUSY=0.
REQ-047 edge field = 0x0500 (index 1280) -> that triangle skipped, err_range=1, the remaining triangles still output.
REQ-048 rst_n low during V_WAIT, then a new request -> clean restart, and edge {7,7,9} is output only when DRAW_TRI_CULL_EN is undefined.
REQ-049 req with cnt=0 -> done_pulse next cycle, no strobes; a second req while BUSY -> ignored.
